// File: rtl/vga_cell_scanner.sv
// VGA raster generator that also tracks game-cell coordinates incrementally, with no divider.
// Sync and data-enable go through a short delay line so they stay aligned with downstream ROM/mixer latency.
module vga_cell_scanner #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL       = 10,
    parameter int SYNC_DELAY = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_en,
    output logic [6:0] o_game_x,
    output logic [6:0] o_game_y,
    output logic [3:0] o_grid_x,
    output logic [3:0] o_grid_y,
    output logic       o_active,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_de,
    output logic       o_frame_start,
    output logic       o_vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0] CELL_LAST = 4'(CELL - 1);

    logic [9:0] h_q, h_d, v_q, v_d;
    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap;
    logic [6:0] game_x_q, game_x_d, game_y_q, game_y_d;
    logic [3:0] grid_x_q, grid_x_d, grid_y_q, grid_y_d;
    logic       active_q, active_d;
    logic       hs_q, hs_d, vs_q, vs_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_start_q, vblank_start_d;

    // Everything is decoded from the position we are about to enter, so each output is registered.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_nxt  = h_wrap ? 10'd0 : h_q + 10'd1;
        v_nxt  = v_q;
        if (h_wrap) begin
            v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end

        h_d            = h_q;
        v_d            = v_q;
        game_x_d       = game_x_q;
        grid_x_d       = grid_x_q;
        game_y_d       = game_y_q;
        grid_y_d       = grid_y_q;
        active_d       = active_q;
        hs_d           = hs_q;
        vs_d           = vs_q;
        frame_start_d  = frame_start_q;
        vblank_start_d = vblank_start_q;

        if (i_pix_en) begin
            h_d = h_nxt;
            v_d = v_nxt;

            if (h_nxt != 10'd0 && h_nxt < H_ACT) begin
                if (grid_x_q == CELL_LAST) begin
                    grid_x_d = 4'd0;
                    game_x_d = game_x_q + 7'd1;
                end else begin
                    grid_x_d = grid_x_q + 4'd1;
                end
            end else begin
                grid_x_d = 4'd0;
                game_x_d = 7'd0;
            end

            // Rows step only at the line wrap; blank lines park the y coordinates at zero.
            if (h_wrap) begin
                if (v_nxt != 10'd0 && v_nxt < V_ACT) begin
                    if (grid_y_q == CELL_LAST) begin
                        grid_y_d = 4'd0;
                        game_y_d = game_y_q + 7'd1;
                    end else begin
                        grid_y_d = grid_y_q + 4'd1;
                    end
                end else begin
                    grid_y_d = 4'd0;
                    game_y_d = 7'd0;
                end
            end

            active_d       = (h_nxt < H_ACT) && (v_nxt < V_ACT);
            hs_d           = !((h_nxt >= HS_START) && (h_nxt < HS_END));
            vs_d           = !((v_nxt >= VS_START) && (v_nxt < VS_END));
            frame_start_d  = (h_nxt == 10'd0) && (v_nxt == 10'd0);
            vblank_start_d = (h_nxt == 10'd0) && (v_nxt == V_ACT);
        end
    end

    // Reset parks the raster on the last pixel so the first strobe lands on (0,0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q            <= H_LAST;
            v_q            <= V_LAST;
            game_x_q       <= 7'd0;
            grid_x_q       <= 4'd0;
            game_y_q       <= 7'd0;
            grid_y_q       <= 4'd0;
            active_q       <= 1'b0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            h_q            <= h_d;
            v_q            <= v_d;
            game_x_q       <= game_x_d;
            grid_x_q       <= grid_x_d;
            game_y_q       <= game_y_d;
            grid_y_q       <= grid_y_d;
            active_q       <= active_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign o_game_x       = game_x_q;
    assign o_game_y       = game_y_q;
    assign o_grid_x       = grid_x_q;
    assign o_grid_y       = grid_y_q;
    assign o_active       = active_q;
    assign o_frame_start  = frame_start_q;
    assign o_vblank_start = vblank_start_q;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign o_hsync_n = hs_q;
            assign o_vsync_n = vs_q;
            assign o_de      = active_q;
        end else begin : g_delay
            // Each stage holds {hs_n, vs_n, de}; the blank pattern is 3'b110.
            logic [2:0] dly_q [SYNC_DELAY];
            logic [2:0] dly_d [SYNC_DELAY];

            always_comb begin
                for (int i = 0; i < SYNC_DELAY; i++) begin
                    dly_d[i] = dly_q[i];
                end
                if (i_pix_en) begin
                    dly_d[0] = {hs_q, vs_q, active_q};
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        dly_d[i] = dly_q[i-1];
                    end
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        dly_q[i] <= 3'b110;
                    end
                end else begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign o_hsync_n = dly_q[SYNC_DELAY-1][2];
            assign o_vsync_n = dly_q[SYNC_DELAY-1][1];
            assign o_de      = dly_q[SYNC_DELAY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_vga_cell_scanner.sv
// Randomized bench for vga_cell_scanner using a reduced raster so several full frames fit in the run.
// Expected outputs are derived arithmetically from the number of enabled strobes since reset.
module tb_vga_cell_scanner;

    localparam int HA = 70, HF = 5, HS = 8, HB = 6;
    localparam int VA = 28, VF = 3, VS = 2, VB = 4;
    localparam int CELL = 7;
    localparam int SD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [6:0] game_x, game_y;
    logic [3:0] grid_x, grid_y;
    logic       active, hsync_n, vsync_n, de, frame_start, vblank_start;

    int n = 0;
    int strobe_cnt = 0;
    int last_fs = -1;
    logic fs_prev = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_cell_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL(CELL), .SYNC_DELAY(SD)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_pix_en(pix_en),
        .o_game_x(game_x),
        .o_game_y(game_y),
        .o_grid_x(grid_x),
        .o_grid_y(grid_y),
        .o_active(active),
        .o_hsync_n(hsync_n),
        .o_vsync_n(vsync_n),
        .o_de(de),
        .o_frame_start(frame_start),
        .o_vblank_start(vblank_start)
    );

    // Strobes since reset; 0 means the reset state, k>=1 means raster position k-1 of the frame.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else if (pix_en) n <= n + 1;
    end

    always @(posedge clk) begin
        if (pix_en) strobe_cnt <= strobe_cnt + 1;
    end

    function automatic logic [27:0] model(input int k);
        int p, h, v, d;
        logic [6:0] gx, gy;
        logic [3:0] rx, ry;
        logic act, hs, vs, den, fs, vbs;
        gx = 0; gy = 0; rx = 0; ry = 0;
        act = 0; hs = 1; vs = 1; den = 0; fs = 0; vbs = 0;
        if (k >= 1) begin
            p = (k - 1) % FRAME;
            h = p % HT;
            v = p / HT;
            if (h < HA) begin
                gx = 7'(h / CELL);
                rx = 4'(h % CELL);
            end
            if (v < VA) begin
                gy = 7'(v / CELL);
                ry = 4'(v % CELL);
            end
            act = (h < HA) && (v < VA);
            fs  = (p == 0);
            vbs = (h == 0) && (v == VA);
        end
        d = k - SD;
        if (d >= 1) begin
            p = (d - 1) % FRAME;
            h = p % HT;
            v = p / HT;
            hs  = !((h >= HA + HF) && (h < HA + HF + HS));
            vs  = !((v >= VA + VF) && (v < VA + VF + VS));
            den = (h < HA) && (v < VA);
        end
        return {gx, gy, rx, ry, act, hs, vs, den, fs, vbs};
    endfunction

    function automatic logic [27:0] observed();
        return {game_x, game_y, grid_x, grid_y, active, hsync_n, vsync_n, de,
                frame_start, vblank_start};
    endfunction

    task automatic checkOutput(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h (strobe %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic sampleAndCheck();
        checkOutput("pixel", observed(), model(n));
        if (frame_start && !fs_prev) begin
            if (last_fs >= 0)
                checkOutput("frame_len", 28'(strobe_cnt - last_fs), 28'(FRAME));
            last_fs = strobe_cnt;
        end
        fs_prev = frame_start;
    endtask

    // mode 0: enable tied high, 1: random enable, 2: alternating 1,0
    task automatic applyStimulus(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            sampleAndCheck();
            case (mode)
                0: pix_en = 1'b1;
                1: pix_en = 1'($urandom_range(0, 1));
                default: pix_en = (i % 2 == 1);
            endcase
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset", observed(), model(0));

        pix_en = 1'b1;
        rst_n  = 1'b1;
        applyStimulus(2 * FRAME + 50, 0);
        applyStimulus(2 * FRAME + 200, 2);
        applyStimulus(2 * FRAME, 1);
        applyStimulus(int'($urandom_range(500, 2000)), 0);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkOutput("async_reset", observed(), model(0));
        last_fs = -1;
        fs_prev = 1'b0;
        pix_en  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", observed(), model(0));
        pix_en = 1'b1;
        rst_n  = 1'b1;
        applyStimulus(FRAME + 20, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
